dcache_writeline_resp: RTL and testbench
========================================

DCACHE_WRITELINE_RESP -- requirements
Module: dcache_writeline_resp

Interface
Parameters: none.
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 writeline_do  input  1  line write request; level, held by initiator until writeline_done.
REQ-005 writeline_address  input  32  byte address of line; bits [3:0] ignored.
REQ-006 writeline_line  input  128  line data; word k = bits [32k+31:32k].
REQ-007 writeline_done  output  1  one-cycle completion pulse.
REQ-008 avm_address  output  30  Avalon word address, bits [31:2] of the byte address.
REQ-009 avm_writedata  output  32  burst write data.
REQ-010 avm_byteenable  output  4  byte enables.
REQ-011 avm_burstcount  output  3  burst length.
REQ-012 avm_write  output  1  write request.
REQ-013 avm_waitrequest  input  1  slave stall; beat accepted when avm_write & ~avm_waitrequest.
REQ-014 busy  output  1  high while state = WRITE.

Function
REQ-015 States SHALL be IDLE and WRITE, with a 2-bit beat counter.
REQ-016 In IDLE with writeline_do = 1, the block SHALL:
- latch writeline_address[31:4] and writeline_line;
- clear the beat counter;
- enter WRITE on the next edge.
REQ-017 In IDLE, the block SHALL hold these values:
- avm_write = 0, writeline_done = 0;
- writeline_address and writeline_line are not sampled while writeline_do = 0.
REQ-018 In WRITE, the block SHALL drive:
- avm_write = 1;
- avm_address = {latched addr[31:4], 2'b00}, constant for the whole burst;
- avm_burstcount = 3'd4;
- avm_byteenable = 4'hF;
- avm_writedata = latched word[beat counter].
REQ-019 On each cycle in WRITE with avm_waitrequest = 0, the beat counter SHALL increment by 1.
REQ-020 While avm_waitrequest = 1, all avm_* outputs and the beat counter SHALL hold unchanged.
REQ-021 writeline_done SHALL be combinational, high exactly in the cycle where state = WRITE, counter = 3 and avm_waitrequest = 0.
REQ-022 The state SHALL return to IDLE on the edge that ends the REQ-021 cycle.
REQ-023 After returning to IDLE, writeline_do sampled high SHALL start a new request, so back-to-back lines have exactly one IDLE cycle between bursts.
REQ-024 Minimum latency from writeline_do rising to writeline_done SHALL be 5 cycles: 1 IDLE cycle plus 4 beats.
REQ-025 Changes to writeline_address or writeline_line during WRITE SHALL have no effect on the burst in progress.
REQ-026 Deassertion of writeline_do during WRITE is a protocol violation; the burst SHALL still complete and done SHALL still pulse.
REQ-027 The beat counter SHALL wrap 3 -> 0 only on completion; no beat beyond the 4th SHALL be issued.

Reset
REQ-028 While rst_n = 0, the block SHALL hold, independent of clk:
- state = IDLE, counter = 0;
- avm_write = 0, writeline_done = 0, busy = 0;
- avm_address = 0, avm_writedata = 0, avm_burstcount = 0, avm_byteenable = 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately, with no done pulse.
REQ-030 After rst_n deasserts, the first action SHALL be IDLE sampling writeline_do.

Verification
REQ-031 Directed scenarios the bench SHALL cover:
- Single line, no stall: address 0x0001_2348, line 0x44444444_33333333_22222222_11111111, waitrequest = 0.
  Beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 at avm_address 0x0000_48D0, burstcount 4, byteenable F; done on the 4th beat cycle; 5 cycles total.
- Stall: waitrequest = 1 for 3 cycles on beat 2.
  Beat 2 data and address held for those cycles; done delayed by exactly 3 cycles.
- Back-to-back: do held continuously across two lines at 0x100 and 0x110.
  Two 4-beat bursts, avm_address 0x40 then 0x44, one idle cycle between bursts, two done pulses.
- Input change mid-burst: writeline_line altered after acceptance.
  Emitted beats equal the values latched at acceptance.
- Reset mid-burst: rst_n low during beat 1.
  avm_write = 0 and busy = 0 asynchronously, no done pulse; a new request after reset completes normally.

Source files
------------

// File: rtl/dcache_writeline_resp.sv
// Writes one 128-bit cache line to an Avalon-MM slave as a 4-beat, 32-bit burst.
// A level-held request is latched in IDLE, and the line is then replayed from those latched copies.
module dcache_writeline_resp (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         writeline_do,
  input  logic [31:0]  writeline_address,
  input  logic [127:0] writeline_line,
  output logic         writeline_done,
  output logic [29:0]  avm_address,
  output logic [31:0]  avm_writedata,
  output logic [3:0]   avm_byteenable,
  output logic [2:0]   avm_burstcount,
  output logic         avm_write,
  input  logic         avm_waitrequest,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for writeline_do; latches address/line when it is seen
  // WRITE | issuing the 4-beat burst from the latched copies
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [27:0]   addr_q, addr_d;
  logic [127:0]  line_q, line_d;
  logic [31:0]   beat_word;

  // Byte offset within the line is implied by the beat index, so the low nibble is dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^writeline_address[3:0];

  always_comb begin
    case (beat_q)
      2'd0:    beat_word = line_q[31:0];
      2'd1:    beat_word = line_q[63:32];
      2'd2:    beat_word = line_q[95:64];
      default: beat_word = line_q[127:96];
    endcase
  end

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    addr_d         = addr_q;
    line_d         = line_q;
    writeline_done = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_burstcount = '0;
    avm_byteenable = '0;
    busy           = 1'b0;

    case (state_q)
      IDLE: begin
        if (writeline_do) begin
          addr_d  = writeline_address[31:4];
          line_d  = writeline_line;
          beat_d  = 2'd0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_address    = {addr_q, 2'b00};
        avm_burstcount = 3'd4;
        avm_byteenable = 4'hF;
        avm_writedata  = beat_word;
        // The counter wraps 3 -> 0 only on the final accepted beat, which is also the exit.
        if (!avm_waitrequest) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            writeline_done = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_dcache_writeline_resp.sv
// Directed bench for dcache_writeline_resp: single line, stall, back-to-back lines,
// input changes during a burst, and reset in the middle of a burst.
module tb_dcache_writeline_resp;

  logic         clk;
  logic         rst_n;
  logic         writeline_do;
  logic [31:0]  writeline_address;
  logic [127:0] writeline_line;
  logic         writeline_done;
  logic [29:0]  avm_address;
  logic [31:0]  avm_writedata;
  logic [3:0]   avm_byteenable;
  logic [2:0]   avm_burstcount;
  logic         avm_write;
  logic         avm_waitrequest;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_seen = 0;

  dcache_writeline_resp dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .writeline_do      (writeline_do),
    .writeline_address (writeline_address),
    .writeline_line    (writeline_line),
    .writeline_done    (writeline_done),
    .avm_address       (avm_address),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_burstcount    (avm_burstcount),
    .avm_write         (avm_write),
    .avm_waitrequest   (avm_waitrequest),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_write"}, avm_write, 1'b0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_done"},  writeline_done, 1'b0);
  endtask

  // One IDLE cycle; do_v=1 makes it the acceptance cycle and restarts the latency count.
  task automatic idle_cycle(input string tag, input logic do_v,
                            input logic [31:0] addr, input logic [127:0] line);
    @(negedge clk);
    writeline_do      = do_v;
    writeline_address = addr;
    writeline_line    = line;
    avm_waitrequest   = 1'b0;
    #1;
    chk_quiet(tag);
    cyc = 1;
  endtask

  // Runs the WRITE phase, checking every cycle; stall_n cycles of waitrequest on beat stall_beat.
  task automatic burst(input string tag, input logic [29:0] exp_addr, input logic [127:0] exp_line,
                       input int stall_beat, input int stall_n, input logic do_after,
                       input logic mangle);
    int k = 0;
    int stalls = 0;
    logic [31:0] w;
    while (k < 4) begin
      @(negedge clk);
      avm_waitrequest = (k == stall_beat) && (stalls < stall_n);
      if (mangle && k == 1) begin
        writeline_line    = ~exp_line;
        writeline_address = 32'hDEAD_BEEF;
      end
      if (k == 3 && !avm_waitrequest) writeline_do = do_after;
      #1;
      w = exp_line[32*k +: 32];
      chk({tag, "_write"}, avm_write, 1'b1);
      chk({tag, "_busy"},  busy, 1'b1);
      chk({tag, "_addr"},  avm_address, exp_addr);
      chk({tag, "_data"},  avm_writedata, w);
      chk({tag, "_bc"},    avm_burstcount, 3'd4);
      chk({tag, "_be"},    avm_byteenable, 4'hF);
      chk({tag, "_done"},  writeline_done, (k == 3) && !avm_waitrequest);
      if (writeline_done) done_seen++;
      cyc++;
      if (avm_waitrequest) stalls++;
      else k++;
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    writeline_do      = 1'b0;
    writeline_address = '0;
    writeline_line    = '0;
    avm_waitrequest   = 1'b0;

    #3;
    chk_quiet("rst");
    chk("rst_addr", avm_address, 30'h0);
    chk("rst_data", avm_writedata, 32'h0);
    chk("rst_bc",   avm_burstcount, 3'd0);
    chk("rst_be",   avm_byteenable, 4'h0);
    writeline_do = 1'b1;
    @(negedge clk);
    #1;
    chk_quiet("rst_do_ignored");
    writeline_do = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single line, no stall
    idle_cycle("s1_idle", 1'b1, 32'h0001_2348, 128'h44444444_33333333_22222222_11111111);
    burst("s1", 30'h0000_48D0, 128'h44444444_33333333_22222222_11111111, -1, 0, 1'b0, 1'b0);
    chk("s1_latency", cyc, 5);
    idle_cycle("s1_after", 1'b0, 32'h0, 128'h0);
    idle_cycle("s1_after2", 1'b0, 32'h0, 128'h0);

    // Three stall cycles on beat 2
    idle_cycle("s2_idle", 1'b1, 32'h0000_0A50, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000);
    burst("s2", 30'h0000_0294, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 2, 3, 1'b0, 1'b0);
    chk("s2_latency", cyc, 8);
    idle_cycle("s2_after", 1'b0, 32'h0, 128'h0);

    // Back-to-back lines with do held high
    done_seen = 0;
    idle_cycle("b2b_idle1", 1'b1, 32'h0000_0100, 128'h0000000D_0000000C_0000000B_0000000A);
    burst("b2b1", 30'h40, 128'h0000000D_0000000C_0000000B_0000000A, -1, 0, 1'b1, 1'b0);
    idle_cycle("b2b_gap", 1'b1, 32'h0000_0110, 128'h00000014_00000013_00000012_00000011);
    burst("b2b2", 30'h44, 128'h00000014_00000013_00000012_00000011, -1, 0, 1'b0, 1'b0);
    chk("b2b_dones", done_seen, 2);
    idle_cycle("b2b_after", 1'b0, 32'h0, 128'h0);

    // Inputs altered after acceptance, plus a one-cycle stall on beat 0
    idle_cycle("mg_idle", 1'b1, 32'h1000_0000, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    burst("mg", 30'h0400_0000, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 1, 1'b0, 1'b1);
    chk("mg_latency", cyc, 6);
    idle_cycle("mg_after", 1'b0, 32'h0, 128'h0);

    // Reset during beat 1
    done_seen = 0;
    idle_cycle("rm_idle", 1'b1, 32'h0000_0300, 128'h4_00000003_00000002_00000001);
    @(negedge clk);
    #1;
    chk("rm_beat0", avm_writedata, 32'h1);
    @(negedge clk);
    #1;
    chk("rm_beat1", avm_writedata, 32'h2);
    rst_n = 1'b0;
    #1;
    chk_quiet("rm_async");
    chk("rm_addr", avm_address, 30'h0);
    chk("rm_data", avm_writedata, 32'h0);
    writeline_do = 1'b0;
    @(negedge clk);
    #1;
    chk_quiet("rm_held");
    rst_n = 1'b1;
    idle_cycle("rm_post", 1'b0, 32'h0, 128'h0);
    chk("rm_no_done", done_seen, 0);
    idle_cycle("rm_new_idle", 1'b1, 32'h0000_0200, 128'h88888888_77777777_66666666_55555555);
    burst("rm_new", 30'h80, 128'h88888888_77777777_66666666_55555555, -1, 0, 1'b0, 1'b0);
    chk("rm_new_latency", cyc, 5);
    idle_cycle("rm_end", 1'b0, 32'h0, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
